// File: rtl/text_stream_writer.sv
// text_stream_writer: turns an ASCII byte stream into character-buffer writes.
// It tracks a terminal cursor, emits one-cycle write pulses for printable
// characters and backspace erase, and sweeps the whole screen with spaces on
// reset and form feed.
//
// Ports:
//   clk_20_mhz   in   pixel-domain clock
//   reset        in   synchronous, active-high
//   in_data      in   byte to process
//   in_valid     in   in_data valid
//   in_ready     out  byte accepted this cycle when in_valid is also high
//   address      out  buffer cell address (row*COLS+col)
//   char_input   out  ASCII code to write
//   write_enable out  one-cycle write strobe
//   cursor_col   out  current cursor column
//   cursor_row   out  current cursor row
module text_stream_writer #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 25,
    parameter int unsigned ADDR_W = 11,
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              clk_20_mhz,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic [6:0]        char_input,
    output logic              write_enable,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row
);

    localparam int unsigned       CELLS     = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);

    if (64'(CELLS) > (64'd1 << ADDR_W)) begin : g_size_check
        $error("text_stream_writer: COLS*ROWS does not fit in ADDR_W address bits");
    end

    typedef enum logic {StClear, StIdle} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;   // linear cursor address, always row*COLS+col
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [6:0]        wchar_q, wchar_d;
    logic [ADDR_W-1:0] line_start;

    // Start of the current row, derived without a multiplier.
    assign line_start = addr_q - ADDR_W'(col_q);

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        ready_d = 1'b0;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wchar_d = wchar_q;

        unique case (state_q)
            StClear: begin
                we_d    = 1'b1;
                waddr_d = sweep_q;
                wchar_d = 7'h20;
                if (sweep_q == LAST_CELL) begin
                    state_d = StIdle;
                    sweep_d = '0;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end else begin
                    sweep_d = sweep_q + ADDR_W'(1);
                end
            end
            StIdle: begin
                ready_d = 1'b1;
                if (in_valid && ready_q) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wchar_d = in_data[6:0];
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d  = '0;
                                addr_d = '0;
                            end else begin
                                row_d  = row_q + ROW_W'(1);
                                addr_d = addr_q + ADDR_W'(1);
                            end
                        end else begin
                            col_d  = col_q + COL_W'(1);
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end else begin
                        case (in_data)
                            8'h0D: begin
                                col_d  = '0;
                                addr_d = line_start;
                            end
                            8'h0A: begin
                                col_d = '0;
                                if (row_q == ROW_LAST) begin
                                    row_d  = '0;
                                    addr_d = '0;
                                end else begin
                                    row_d  = row_q + ROW_W'(1);
                                    addr_d = line_start + ROW_STEP;
                                end
                            end
                            8'h08: begin
                                // Backspace never crosses to the previous row.
                                if (col_q != '0) begin
                                    col_d   = col_q - COL_W'(1);
                                    addr_d  = addr_q - ADDR_W'(1);
                                    we_d    = 1'b1;
                                    waddr_d = addr_q - ADDR_W'(1);
                                    wchar_d = 7'h20;
                                end
                            end
                            8'h0C: begin
                                // Cursor keeps its position until the sweep ends.
                                state_d = StClear;
                                sweep_d = '0;
                                ready_d = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_20_mhz) begin
        if (reset) begin
            state_q <= StClear;
            sweep_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wchar_q <= 7'h20;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wchar_q <= wchar_d;
        end
    end

    assign in_ready     = ready_q;
    assign write_enable = we_q;
    assign address      = waddr_q;
    assign char_input   = wchar_q;
    assign cursor_col   = col_q;
    assign cursor_row   = row_q;

endmodule

// File: tb/tb_text_stream_writer.sv
module tb_text_stream_writer;

    localparam int COLS   = 80;
    localparam int ROWS   = 25;
    localparam int ADDR_W = 11;
    localparam int CELLS  = COLS * ROWS;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] address;
    logic [6:0]        char_input;
    logic              write_enable;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;

    text_stream_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk_20_mhz  (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .address     (address),
        .char_input  (char_input),
        .write_enable(write_enable),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row)
    );

    always #25 clk = ~clk;

    typedef struct packed {
        logic       clr;
        logic [10:0] addr;
        logic [6:0] ch;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   m_col  = 0;
    int   m_row  = 0;
    logic ready_due = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    task automatic push_write(input logic clr, input int a, input logic [6:0] c);
        exp_t e;
        e.clr  = clr;
        e.addr = 11'(a);
        e.ch   = c;
        exp_q.push_back(e);
    endtask

    task automatic push_clear();
        for (int k = 0; k < CELLS; k++) push_write(1'b1, k, 7'h20);
        m_col = 0;
        m_row = 0;
    endtask

    // Terminal behaviour expressed with (col,row) and row*COLS+col.
    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_write(1'b0, m_row * COLS + m_col, b[6:0]);
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_write(1'b0, m_row * COLS + m_col, 7'h20);
            end
        end else if (b == 8'h0C) begin
            push_clear();
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (ready_due) begin
            chk("ready_after_clear", int'(in_ready), 1);
            ready_due = 1'b0;
        end
        if (write_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got addr %0d char %0h, expected no write at %0t",
                         address, char_input, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("write_addr", int'(address), int'(e.addr));
                chk("write_char", int'(char_input), int'(e.ch));
                if (e.clr) begin
                    chk("ready_low_in_clear", int'(in_ready), 0);
                    if (int'(e.addr) == CELLS - 1) ready_due = 1'b1;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL accept_timeout: got in_ready 0, expected 1 within 5000 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_byte(b);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic check_cursor(input string name, input int c, input int r);
        chk({name, "_col"}, int'(cursor_col), c);
        chk({name, "_row"}, int'(cursor_row), r);
    endtask

    task automatic check_reset_outputs();
        chk("rst_we", int'(write_enable), 0);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_addr", int'(address), 0);
        chk("rst_char", int'(char_input), 32);
        check_cursor("rst_cursor", 0, 0);
    endtask

    initial begin
        int n;
        logic [7:0] b;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b0;
        push_clear();

        // 1: power-on sweep
        drain("t1_sweep_done");
        chk("t1_ready", int'(in_ready), 1);
        check_cursor("t1_cursor", 0, 0);

        // 2: back-to-back printable bytes
        send_byte("H");
        send_byte("i");
        idle(2);
        check_cursor("t2_cursor", 2, 0);

        // 3: line wrap after column 79
        send_byte(8'h0D);
        for (int i = 0; i < COLS; i++) send_byte("A");
        send_byte("B");
        idle(2);
        check_cursor("t3_cursor", 1, 1);

        // 4: LF from the bottom row wraps to the top
        send_byte(8'h0D);
        for (int i = 0; i < 23; i++) send_byte(8'h0A);
        for (int i = 0; i < 5; i++) send_byte("q");
        check_cursor("t4_pre", 5, 24);
        send_byte(8'h0A);
        send_byte("x");
        idle(2);
        check_cursor("t4_cursor", 1, 0);

        // 5: backspace erase and backspace at column 0
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_byte(8'h0A);
        for (int i = 0; i < 3; i++) send_byte("z");
        send_byte(8'h08);
        idle(2);
        check_cursor("t5_bs", 2, 2);
        send_byte(8'h0D);
        send_byte(8'h08);
        idle(3);
        check_cursor("t5_bs_col0", 0, 2);
        drain("t5_writes");

        // 6: form feed between bytes with in_valid held high
        send_byte("a");
        send_byte(8'h0C);
        send_byte("b");
        drain("t6_writes");
        check_cursor("t6_cursor", 1, 0);

        // 6b: reset in the middle of a sweep restarts it from 0
        send_byte(8'h0C);
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > CELLS - 500 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check_reset_outputs();
        reset = 1'b0;
        push_clear();
        drain("t6_restart_sweep");
        chk("t6_ready", int'(in_ready), 1);
        check_cursor("t6_rst_cursor", 0, 0);

        // Randomised stream against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 75) b = 8'h0D;
            else if (r < 80) b = 8'h0A;
            else if (r < 90) b = 8'h08;
            else if (r < 94) b = 8'h7F;
            else if (r < 97) b = 8'h80 | 8'($urandom_range(0, 127));
            else             b = 8'h1B;
            send_byte(b);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            if (i % 50 == 49) check_cursor("rand_cursor", m_col, m_row);
        end
        drain("rand_writes");
        check_cursor("rand_final", m_col, m_row);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
